// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the SRAM port arbiter.
// IDLE: arbitrate | ISSUE: drive port | WAIT: RD_LAT cycles | RESP: ack and re-arbitrate
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } gnt_t;

    localparam logic [3:0] WEN_LOAD = 4'b0000;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester and shared-port signals of the SRAM arbiter.
// The slave modport is the arbiter; master is the pipeline plus the SRAM.
interface sram_port_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_ack;
    logic [31:0] data_rdata;

    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        stall_req_if;
    logic        stall_req_mem;

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wen, data_addr, data_wdata,
        input  mem_rdata,
        output inst_ack, inst_rdata,
        output data_ack, data_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata,
        output stall_req_if, stall_req_mem
    );

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wen, data_addr, data_wdata,
        output mem_rdata,
        input  inst_ack, inst_rdata,
        input  data_ack, data_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata,
        input  stall_req_if, stall_req_mem
    );

endinterface

// File: rtl/sram_port_arbiter_wait_timer.sv
// Loadable down-counter timing the SRAM read latency.
// done is high whenever the count has reached zero.
module sram_wait_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and the data path.
// Data has priority; a starvation limit guarantees forward progress for fetch.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    sram_port_arbiter_if.slave bus
);

    localparam int TW = $clog2(RD_LAT) + 1;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    gnt_t          r_gnt;
    logic [SW-1:0] r_starve;
    logic          r_store;

    logic          r_mem_en;
    logic [3:0]    r_mem_wen;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic          r_inst_ack;
    logic          r_data_ack;
    logic [31:0]   r_inst_rdata;
    logic [31:0]   r_data_rdata;

    logic          w_arb;
    logic          w_inst_elig;
    logic          w_data_elig;
    logic          w_starved;
    logic          w_pick_data;
    logic          w_pick_inst;
    logic          w_timer_load;
    logic          w_timer_done;
    logic          w_capture;

    // In RESP the acked requester still holds req, so it must not win again.
    always_comb begin
        w_arb       = (r_state == ST_IDLE) || (r_state == ST_RESP);
        w_inst_elig = bus.inst_req && !((r_state == ST_RESP) && (r_gnt == GNT_INST));
        w_data_elig = bus.data_req && !((r_state == ST_RESP) && (r_gnt == GNT_DATA));
        w_starved   = w_inst_elig && (r_starve == SW'(STARVE_MAX));
        w_pick_data = w_arb && w_data_elig && !w_starved;
        w_pick_inst = w_arb && !w_pick_data && w_inst_elig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_load = 1'b0;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                w_state_nxt = (w_pick_data || w_pick_inst) ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                w_timer_load = 1'b1;
                w_state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_timer_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    sram_wait_timer #(
        .W (TW)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_timer_load),
        .i_value (TW'(RD_LAT - 1)),
        .o_done  (w_timer_done)
    );

    assign w_capture = (r_state == ST_WAIT) && w_timer_done;

    // The mem_* registers double as the grant latch: loaded on grant, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt        <= GNT_INST;
            r_store      <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_wen    <= WEN_LOAD;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_ack   <= 1'b0;
            r_data_ack   <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_mem_en    <= w_pick_data || w_pick_inst;
            r_mem_wen   <= WEN_LOAD;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            if (w_pick_data) begin
                r_gnt       <= GNT_DATA;
                r_store     <= (bus.data_wen != WEN_LOAD);
                r_mem_wen   <= bus.data_wen;
                r_mem_addr  <= bus.data_addr;
                r_mem_wdata <= bus.data_wdata;
            end else if (w_pick_inst) begin
                r_gnt      <= GNT_INST;
                r_store    <= 1'b0;
                r_mem_addr <= bus.inst_addr;
            end
            r_inst_ack <= w_capture && (r_gnt == GNT_INST);
            r_data_ack <= w_capture && (r_gnt == GNT_DATA);
            if (w_capture && (r_gnt == GNT_INST)) begin
                r_inst_rdata <= bus.mem_rdata;
            end
            if (w_capture && (r_gnt == GNT_DATA) && !r_store) begin
                r_data_rdata <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pick_data && w_inst_elig) begin
            if (r_starve != SW'(STARVE_MAX)) begin
                r_starve <= r_starve + SW'(1);
            end
        end else if (w_pick_inst || !bus.inst_req) begin
            r_starve <= '0;
        end
    end

    assign bus.mem_en        = r_mem_en;
    assign bus.mem_wen       = r_mem_wen;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.inst_ack      = r_inst_ack;
    assign bus.inst_rdata    = r_inst_rdata;
    assign bus.data_ack      = r_data_ack;
    assign bus.data_rdata    = r_data_rdata;
    assign bus.stall_req_if  = bus.inst_req && !r_inst_ack;
    assign bus.stall_req_mem = bus.data_req && !r_data_ack;

endmodule
